// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for pipelined_carry_adder.
// The sub signal exists only when RCA_SUB_EN is defined.
interface pipelined_carry_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef RCA_SUB_EN
  logic             sub;
`endif
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

`ifdef RCA_SUB_EN
  modport master (output a, b, cin, sub, in_valid, out_ready,
                  input  in_ready, sum, cout, ovf, out_valid);
  modport slave  (input  a, b, cin, sub, in_valid, out_ready,
                  output in_ready, sum, cout, ovf, out_valid);
`else
  modport master (output a, b, cin, in_valid, out_ready,
                  input  in_ready, sum, cout, ovf, out_valid);
  modport slave  (input  a, b, cin, in_valid, out_ready,
                  output in_ready, sum, cout, ovf, out_valid);
`endif
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined carry-propagate adder: one CHUNK-bit slice per stage, carry registered between stages.
// Define RCA_SUB_EN to add the sub input (a - b computed as a + ~b + 1).
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_carry_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int MSB    = WIDTH - 1;

  logic             r_vld [STAGES];
  logic             r_cy  [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_ovf;

  logic             w_adv;
  logic [WIDTH-1:0] w_b0;
  logic             w_cin0;
  logic             w_vld_in  [STAGES];
  logic             w_cy_in   [STAGES];
  logic [WIDTH-1:0] w_a_in    [STAGES];
  logic [WIDTH-1:0] w_b_in    [STAGES];
  logic [WIDTH-1:0] w_sum_in  [STAGES];
  logic [CHUNK:0]   w_slice   [STAGES];
  logic [WIDTH-1:0] w_sum_nxt [STAGES];
  logic             w_ovf_nxt;

  // B is inverted once at capture so every later stage only ever adds.
`ifdef RCA_SUB_EN
  assign w_b0   = bus.sub ? ~bus.b : bus.b;
  assign w_cin0 = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b0   = bus.b;
  assign w_cin0 = bus.cin;
`endif

  assign w_adv         = !r_vld[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.cout      = r_cy[STAGES-1];
  assign bus.ovf       = r_ovf;

  // Stage inputs: stage 0 from the ports, stage k from stage k-1.
  always_comb begin
    w_vld_in[0] = bus.in_valid;
    w_cy_in[0]  = w_cin0;
    w_a_in[0]   = bus.a;
    w_b_in[0]   = w_b0;
    w_sum_in[0] = {WIDTH{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      w_vld_in[k] = r_vld[k-1];
      w_cy_in[k]  = r_cy[k-1];
      w_a_in[k]   = r_a[k-1];
      w_b_in[k]   = r_b[k-1];
      w_sum_in[k] = r_sum[k-1];
    end
  end

  // One CHUNK-bit ripple per stage, merged into the running sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_slice[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                 + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_cy_in[k]};
      w_sum_nxt[k] = w_sum_in[k];
      w_sum_nxt[k][k*CHUNK +: CHUNK] = w_slice[k][CHUNK-1:0];
    end
    w_ovf_nxt = (w_a_in[STAGES-1][MSB] == w_b_in[STAGES-1][MSB]) &&
                (w_sum_nxt[STAGES-1][MSB] != w_a_in[STAGES-1][MSB]);
  end

  // Whole pipeline shifts together whenever the output slot is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_cy[k]  <= 1'b0;
        r_a[k]   <= {WIDTH{1'b0}};
        r_b[k]   <= {WIDTH{1'b0}};
        r_sum[k] <= {WIDTH{1'b0}};
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_cy[k]  <= w_slice[k][CHUNK];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_nxt[k];
      end
      r_ovf <= w_ovf_nxt;
    end
  end
endmodule
